// File: rtl/lfsr_bram_buffer.sv
// lfsr_bram_buffer
//   Pseudo-random sample recorder. A 4-bit Fibonacci LFSR (x^4+x^3+1) steps
//   once per sample tick. When bram_write_enable is high on a tick, the
//   pre-advance LFSR value goes into an 8-entry circular buffer that maps to
//   block RAM. A registered debug port reads any entry. The sample rate comes
//   from a clock-enable divider, so everything runs on one clock.
//
// Ports
//   clk                in   system clock, rising edge
//   reset              in   asynchronous active-low reset
//   bram_write_enable  in   on a tick, 1 = store the current LFSR value
//   rd_addr            in   debug read address
//   rd_data            out  bram[rd_addr], one cycle of latency
//   lfsr_out           out  current LFSR state
//   bram_out           out  value of the most recent write
//   wr_ptr             out  entry that the next write goes to
//   sample_tick        out  one-cycle pulse on each tick cycle
//   full               out  sticky, set once all DEPTH entries are written

module lfsr_bram_buffer #(
  parameter int                   DATA_W   = 4,
  parameter int                   DEPTH    = 8,
  parameter int                   TICK_DIV = 12,
  parameter logic [DATA_W-1:0]    SEED     = DATA_W'(1),
  localparam int                  ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bram_write_enable,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] lfsr_out,
  output logic [DATA_W-1:0] bram_out,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              sample_tick,
  output logic              full
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  logic [DIV_W-1:0]  r_div;
  logic [DATA_W-1:0] r_lfsr;
  logic [DATA_W-1:0] r_bram_out;
  logic [DATA_W-1:0] r_rd_data;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_full;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_tick;
  logic              w_wr;
  logic [DATA_W-1:0] w_lfsr_next;

  assign w_tick = (r_div == DIV_LAST);
  assign w_wr   = w_tick & bram_write_enable;

  // An all-zero state would lock up the LFSR, so it reloads the seed instead.
  assign w_lfsr_next = (r_lfsr == '0) ? SEED
                     : {r_lfsr[DATA_W-2:0], r_lfsr[DATA_W-1] ^ r_lfsr[DATA_W-2]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr     <= SEED;
      r_bram_out <= '0;
      r_wr_ptr   <= '0;
      r_full     <= 1'b0;
    end else begin
      if (w_tick) r_lfsr <= w_lfsr_next;
      if (w_wr) begin
        r_bram_out <= r_lfsr;
        r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
        if (r_wr_ptr == PTR_LAST) r_full <= 1'b1;
      end
    end
  end

  // The storage array has no reset so that it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_lfsr;
  end

  // Read-before-write: a read that collides with a write returns the old entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rd_data <= '0;
    else        r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data     = r_rd_data;
  assign lfsr_out    = r_lfsr;
  assign bram_out    = r_bram_out;
  assign wr_ptr      = r_wr_ptr;
  assign full        = r_full;
  // With TICK_DIV=1 the compare is always true, so keep the pulse low in reset.
  assign sample_tick = w_tick & reset;

endmodule

// File: tb/tb_lfsr_bram_buffer.sv
module tb_lfsr_bram_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] ra;
  logic [3:0] rd_data, lfsr_out, bram_out;
  logic [2:0] wr_ptr;
  logic       sample_tick, full;

  logic       en1 = 1'b1;
  logic [2:0] ra1 = 3'd0;
  logic [3:0] rd_data1, lfsr_out1, bram_out1;
  logic [2:0] wr_ptr1;
  logic       sample_tick1, full1;

  always #5 clk = ~clk;

  lfsr_bram_buffer #(.DATA_W(4), .DEPTH(8), .TICK_DIV(12), .SEED(4'b0001)) u_dut (
    .clk(clk), .reset(reset), .bram_write_enable(en), .rd_addr(ra),
    .rd_data(rd_data), .lfsr_out(lfsr_out), .bram_out(bram_out),
    .wr_ptr(wr_ptr), .sample_tick(sample_tick), .full(full)
  );

  lfsr_bram_buffer #(.DATA_W(4), .DEPTH(8), .TICK_DIV(1), .SEED(4'b0001)) u_dut1 (
    .clk(clk), .reset(reset), .bram_write_enable(en1), .rd_addr(ra1),
    .rd_data(rd_data1), .lfsr_out(lfsr_out1), .bram_out(bram_out1),
    .wr_ptr(wr_ptr1), .sample_tick(sample_tick1), .full(full1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: sample count, buffer as an array, pointer as an integer.
  int m_lfsr, m_ptr, m_bout, m_div, m_ticks, m1_lfsr;
  bit m_full;
  int m_mem [8];
  bit m_vld [8];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // x^4+x^3+1: shift left, feed back bit3 xor bit2; zero reloads the seed.
  function automatic int lfsr_next(input int q);
    if (q == 0) return 1;
    return ((q << 1) & 15) | (((q >> 3) ^ (q >> 2)) & 1);
  endfunction

  task automatic model_reset();
    m_lfsr = 1; m_ptr = 0; m_bout = 0; m_div = 0; m_full = 0; m1_lfsr = 1;
  endtask

  task automatic step();
    int  exp_rd;
    bit  rd_known;
    bit  tick;
    rd_known = m_vld[ra];
    exp_rd   = m_mem[ra];
    tick     = (m_div == 11);
    @(posedge clk);
    if (tick) begin
      if (en) begin
        m_mem[m_ptr] = m_lfsr;
        m_vld[m_ptr] = 1;
        m_bout       = m_lfsr;
        if (m_ptr == 7) m_full = 1;
        m_ptr = (m_ptr + 1) % 8;
      end
      m_lfsr = lfsr_next(m_lfsr);
      m_ticks++;
      m_div = 0;
    end else begin
      m_div++;
    end
    m1_lfsr = lfsr_next(m1_lfsr);
    #1;
    check_val("lfsr", lfsr_out, m_lfsr);
    check_val("bram_out", bram_out, m_bout);
    check_val("wr_ptr", wr_ptr, m_ptr);
    check_val("full", full, m_full);
    check_val("tick", sample_tick, m_div == 11);
    if (rd_known) check_val("rd_data", rd_data, exp_rd);
    check_val("div1_lfsr", lfsr_out1, m1_lfsr);
    check_val("div1_tick", sample_tick1, 1);
  endtask

  // mode 0: enabled, 1: disabled, 2: random enable
  task automatic run_ticks(input int n, input int mode);
    int target;
    target = m_ticks + n;
    while (m_ticks < target) begin
      en = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      ra = 3'($urandom_range(0, 7));
      step();
    end
  endtask

  task automatic read_back(input string tag, input int tbl [8]);
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i);
      step();
      check_val(tag, rd_data, tbl[i]);
    end
  endtask

  int tbl1 [8] = '{1, 2, 4, 9, 3, 6, 13, 10};
  int tbl2 [8] = '{5, 11, 7, 9, 3, 6, 13, 10};

  initial begin
    reset = 1'b0; en = 1'b0; ra = 3'd0; m_ticks = 0;
    for (int i = 0; i < 8; i++) begin m_vld[i] = 0; m_mem[i] = 0; end
    model_reset();
    #12;
    check_val("rst_lfsr", lfsr_out, 1);
    check_val("rst_bram_out", bram_out, 0);
    check_val("rst_rd_data", rd_data, 0);
    check_val("rst_wr_ptr", wr_ptr, 0);
    check_val("rst_full", full, 0);
    check_val("rst_tick", sample_tick, 0);
    check_val("rst_tick1", sample_tick1, 0);
    @(negedge clk); reset = 1'b1;

    run_ticks(8, 0);
    check_val("fill_full", full, 1);
    check_val("fill_ptr", wr_ptr, 0);
    check_val("fill_bram_out", bram_out, 4'b1010);
    read_back("fill_entry", tbl1);

    run_ticks(3, 0);
    read_back("wrap_entry", tbl2);
    check_val("wrap_ptr", wr_ptr, 3);
    check_val("wrap_full", full, 1);

    run_ticks(4, 1);
    check_val("dis_ptr", wr_ptr, 3);
    check_val("dis_bram_out", bram_out, 4'b0111);
    check_val("dis_full", full, 1);
    check_val("period", lfsr_out, 1);
    read_back("dis_entry", tbl2);

    run_ticks(40, 2);

    @(negedge clk); #2 reset = 1'b0; #1;
    check_val("mid_lfsr", lfsr_out, 1);
    check_val("mid_ptr", wr_ptr, 0);
    check_val("mid_full", full, 0);
    check_val("mid_bram_out", bram_out, 0);
    check_val("mid_rd_data", rd_data, 0);
    check_val("mid_tick", sample_tick, 0);
    check_val("mid_tick1", sample_tick1, 0);
    model_reset();
    @(negedge clk); reset = 1'b1;

    run_ticks(1, 0);
    ra = 3'd0;
    step();
    check_val("restart_entry0", rd_data, 1);
    run_ticks(12, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit %0d", 200000);
    $fatal(1);
  end

endmodule
